// File: rtl/tdm_scan8_pkg.sv
// Shared types and constants for the 8-channel TDM scanner.
package tdm_scan8_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned NumChan    = 8;
  localparam int unsigned ChanWidth  = $clog2(NumChan);
  localparam logic [ChanWidth-1:0] LastChan = 3'd7;
  localparam int unsigned DwellWidth = 4;

endpackage

// File: rtl/tdm_scan8_if.sv
// Request/frame inputs and selector-facing outputs of the TDM scanner.
interface tdm_scan8_if;
  import tdm_scan8_pkg::*;

  logic                  start;
  logic [7:0]            iFrame;
  logic [DwellWidth-1:0] iDwell;
  logic [7:0]            oData;
  logic                  A;
  logic                  B;
  logic                  C;
  logic                  valid;
  logic                  busy;
  logic                  done;

  modport master (
    output start, iFrame, iDwell,
    input  oData, A, B, C, valid, busy, done
  );

  modport slave (
    input  start, iFrame, iDwell,
    output oData, A, B, C, valid, busy, done
  );

endinterface

// File: rtl/tdm_scan8_dwell_timer.sv
// Per-channel dwell counter: counts 0..limit while enabled, flags the last cycle.
module dwell_timer
  import tdm_scan8_pkg::*;
#(
  parameter int unsigned Width = DwellWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [Width-1:0] limit_i,
  output logic             tc_o
);

  logic [Width-1:0] count_q;

  // Terminal count only means something while the count is advancing.
  assign tc_o = en_i && (count_q == limit_i);

  // Counter clears on reset/clear and wraps to zero at terminal count.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= tc_o ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_scan8.sv
// Scans a captured 8-bit frame across an 8-channel selector, one channel per dwell period.
module tdm_scan8
  import tdm_scan8_pkg::*;
(
  input logic        clk,
  input logic        rst,
  tdm_scan8_if.slave bus
);

  state_e                state_q;
  logic [ChanWidth-1:0]  chan_q;
  logic [DwellWidth-1:0] dwell_q;
  logic [7:0]            data_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  timer_clr;
  logic                  timer_en;
  logic                  dwell_tc;

  assign timer_en  = (state_q == StScan);
  assign timer_clr = !timer_en;

  dwell_timer #(
    .Width(DwellWidth)
  ) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .clear_i(timer_clr),
    .en_i   (timer_en),
    .limit_i(dwell_q),
    .tc_o   (dwell_tc)
  );

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      chan_q  <= '0;
      dwell_q <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            data_q  <= bus.iFrame;
            dwell_q <= bus.iDwell;
            chan_q  <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StScan;
          end
        end
        StScan: begin
          if (dwell_tc) begin
            // Explicit terminal compare: the channel never wraps within a frame.
            if (chan_q == LastChan) begin
              chan_q  <= '0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              chan_q <= chan_q + 1'b1;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          chan_q  <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.oData = data_q;
  assign bus.A     = chan_q[2];
  assign bus.B     = chan_q[1];
  assign bus.C     = chan_q[0];
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_tdm_scan8.sv
// Scoreboard bench for tdm_scan8: expected per-cycle output words are queued when
// stimulus is driven and compared one per clock on the falling edge.
module tb_tdm_scan8;

  logic clk = 1'b0;
  logic rst;

  tdm_scan8_if bus ();

  tdm_scan8 dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Downstream 8:1 selector model: routes oData bit {A,B,C}.
  logic sel_y;
  always_comb begin
    sel_y = bus.oData[{bus.A, bus.B, bus.C}];
  end

  // Word layout: [13] valid [12] busy [11] done [10:8] channel [7:0] oData.
  logic [13:0] sb[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [13:0] obs_word();
    return {bus.valid, bus.busy, bus.done, bus.A, bus.B, bus.C, bus.oData};
  endfunction

  task automatic push_frame(input logic [7:0] f, input int d);
    for (int ch = 0; ch < 8; ch++) begin
      for (int k = 0; k <= d; k++) sb.push_back({3'b110, 3'(ch), f});
    end
    sb.push_back({3'b011, 3'b000, f});
  endtask

  task automatic push_idle(input logic [7:0] f, input int n);
    for (int k = 0; k < n; k++) sb.push_back({3'b000, 3'b000, f});
  endtask

  // Drive one start pulse on the falling edge side, drop it after it is sampled.
  task automatic pulse_start(input logic [7:0] f, input logic [3:0] d);
    @(negedge clk);
    #1;
    bus.start  = 1'b1;
    bus.iFrame = f;
    bus.iDwell = d;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] e, o;
    int i = 0;
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.iFrame = 8'hFF;
    bus.iDwell = 4'd5;
    push_idle(8'h00, 6);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      o = obs_word();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset cyc%0d got=%h want=%h", i, o, e);
      end
      if (i == 2) begin
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
      end
      i++;
    end
  endtask

  task automatic test_dwell0();
    logic [13:0] e, o;
    int i = 0;
    pulse_start(8'hA5, 4'd0);
    bus.iFrame = 8'h00;
    push_frame(8'hA5, 0);
    push_idle(8'hA5, 2);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      o = obs_word();
      if (e[11]) o[10:8] = e[10:8];
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL dwell0 cyc%0d got=%h want=%h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_dwell3();
    logic [13:0] e, o;
    int i = 0;
    pulse_start(8'h3C, 4'd3);
    push_frame(8'h3C, 3);
    push_idle(8'h3C, 2);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      o = obs_word();
      if (e[11]) o[10:8] = e[10:8];
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL dwell3 cyc%0d got=%h want=%h", i, o, e);
      end
      i++;
    end
  endtask

  // Start during SCAN (channel 4) and on the DONE->IDLE edge must both be ignored.
  task automatic test_ignore_start();
    logic [13:0] e, o;
    int i = 0;
    pulse_start(8'h3C, 4'd3);
    push_frame(8'h3C, 3);
    push_idle(8'h3C, 3);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      o = obs_word();
      if (e[11]) o[10:8] = e[10:8];
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL ignore_start cyc%0d got=%h want=%h", i, o, e);
      end
      if (i == 16 || i == 32) begin
        #1;
        bus.start  = 1'b1;
        bus.iFrame = 8'hFF;
        bus.iDwell = 4'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end
      i++;
    end
  endtask

  // Reset at channel 5 aborts without done; next frame starts fresh at channel 0.
  task automatic test_reset_mid();
    logic [13:0] e, o;
    int i = 0;
    pulse_start(8'hC3, 4'd1);
    push_frame(8'hC3, 1);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      o = obs_word();
      if (e[11]) o[10:8] = e[10:8];
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset_mid cyc%0d got=%h want=%h", i, o, e);
      end
      if (i == 10) begin
        #1;
        rst = 1'b1;
        sb.delete();
        push_idle(8'h00, 3);
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      i++;
    end
    i = 0;
    pulse_start(8'h81, 4'd1);
    push_frame(8'h81, 1);
    push_idle(8'h81, 2);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      o = obs_word();
      if (e[11]) o[10:8] = e[10:8];
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL after_reset cyc%0d got=%h want=%h", i, o, e);
      end
      i++;
    end
  endtask

  // start held high: frames separated by exactly one IDLE cycle.
  task automatic test_back_to_back();
    logic [13:0] e, o;
    int i = 0;
    @(negedge clk);
    #1;
    bus.start  = 1'b1;
    bus.iFrame = 8'h5A;
    bus.iDwell = 4'd0;
    push_frame(8'h5A, 0);
    push_idle(8'h5A, 1);
    push_frame(8'h5A, 0);
    push_idle(8'h5A, 1);
    push_frame(8'h5A, 0);
    push_idle(8'h5A, 2);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      o = obs_word();
      if (e[11]) o[10:8] = e[10:8];
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL back_to_back cyc%0d got=%h want=%h", i, o, e);
      end
      if (i == 24) begin
        #1;
        bus.start = 1'b0;
      end
      i++;
    end
  endtask

  // Downstream selector sees oData bit k while channel k is presented.
  task automatic test_selector();
    logic [13:0] e;
    logic [7:0]  ed;
    logic [7:0]  f;
    int i = 0;
    f = 8'($urandom_range(1, 254));
    pulse_start(f, 4'd0);
    push_frame(f, 0);
    while (sb.size() > 0) begin
      @(negedge clk);
      e  = sb.pop_front();
      ed = e[7:0];
      if (e[13]) begin
        total++;
        if (sel_y !== ed[e[10:8]] || {bus.A, bus.B, bus.C} !== e[10:8]) begin
          bad++;
          $display("FAIL selector ch%0d got=%b want=%b", i, sel_y, ed[e[10:8]]);
        end
      end
      i++;
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.iFrame = 8'h00;
    bus.iDwell = 4'd0;
    test_reset();
    test_dwell0();
    test_dwell3();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_selector();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
